// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Stage k resolves block k and selects its pre-computed sum with the carry held by stage k-1.
module csel_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] tag_out
);

    localparam int NBLK = WIDTH / BLOCK;

    generate
        if ((WIDTH % BLOCK) != 0) begin : g_bad_block
            $error("csel_adder_pipe: WIDTH must be a multiple of BLOCK");
        end
    endgenerate

    logic             adv_s;
    logic             ovf_s;

    logic             src_v_s   [NBLK];
    logic [WIDTH-1:0] src_a_s   [NBLK];
    logic [WIDTH-1:0] src_b_s   [NBLK];
    logic             src_c_s   [NBLK];
    logic [WIDTH-1:0] src_acc_s [NBLK];
    logic [TAG_W-1:0] src_tag_s [NBLK];

    logic [BLOCK:0]   s0_s      [NBLK];
    logic [BLOCK:0]   s1_s      [NBLK];
    logic [WIDTH-1:0] nxt_acc_s [NBLK];
    logic             nxt_c_s   [NBLK];

    logic             valid_r   [NBLK];
    logic [WIDTH-1:0] a_r       [NBLK];
    logic [WIDTH-1:0] b_r       [NBLK];
    logic             carry_r   [NBLK];
    logic [WIDTH-1:0] acc_r     [NBLK];
    logic [TAG_W-1:0] tag_r     [NBLK];
    logic             ovf_r;

    assign adv_s    = ~valid_r[NBLK-1] | out_ready;
    assign in_ready = adv_s & ~rst;

    // Stage inputs: the port operands feed stage 0, every later stage reads its predecessor.
    always_comb begin
        src_v_s[0]   = in_valid & in_ready;
        src_a_s[0]   = a;
        src_b_s[0]   = sub ? ~b : b;
        src_c_s[0]   = sub ? 1'b1 : cin;
        src_acc_s[0] = {WIDTH{1'b0}};
        src_tag_s[0] = tag_in;
        for (int k = 1; k < NBLK; k++) begin
            src_v_s[k]   = valid_r[k-1];
            src_a_s[k]   = a_r[k-1];
            src_b_s[k]   = b_r[k-1];
            src_c_s[k]   = carry_r[k-1];
            src_acc_s[k] = acc_r[k-1];
            src_tag_s[k] = tag_r[k-1];
        end
    end

    // Both conditional block sums per stage, then the carry-select merge into the partial result.
    always_comb begin
        for (int k = 0; k < NBLK; k++) begin
            s0_s[k] = {1'b0, src_a_s[k][k*BLOCK +: BLOCK]} + {1'b0, src_b_s[k][k*BLOCK +: BLOCK]};
            s1_s[k] = {1'b0, src_a_s[k][k*BLOCK +: BLOCK]} + {1'b0, src_b_s[k][k*BLOCK +: BLOCK]}
                      + {{BLOCK{1'b0}}, 1'b1};
            nxt_acc_s[k] = src_acc_s[k];
            if (src_c_s[k]) begin
                nxt_acc_s[k][k*BLOCK +: BLOCK] = s1_s[k][BLOCK-1:0];
                nxt_c_s[k]                     = s1_s[k][BLOCK];
            end else begin
                nxt_acc_s[k][k*BLOCK +: BLOCK] = s0_s[k][BLOCK-1:0];
                nxt_c_s[k]                     = s0_s[k][BLOCK];
            end
        end
        // Signed overflow: like-signed operands producing a result of the other sign.
        ovf_s = (src_a_s[NBLK-1][WIDTH-1] == src_b_s[NBLK-1][WIDTH-1]) &&
                (nxt_acc_s[NBLK-1][WIDTH-1] != src_a_s[NBLK-1][WIDTH-1]);
    end

    // Pipeline registers; data only loads with a valid entry so a bubble leaves outputs untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBLK; k++) begin
                valid_r[k] <= 1'b0;
                a_r[k]     <= {WIDTH{1'b0}};
                b_r[k]     <= {WIDTH{1'b0}};
                carry_r[k] <= 1'b0;
                acc_r[k]   <= {WIDTH{1'b0}};
                tag_r[k]   <= {TAG_W{1'b0}};
            end
            ovf_r <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < NBLK; k++) begin
                valid_r[k] <= src_v_s[k];
                if (src_v_s[k]) begin
                    a_r[k]     <= src_a_s[k];
                    b_r[k]     <= src_b_s[k];
                    carry_r[k] <= nxt_c_s[k];
                    acc_r[k]   <= nxt_acc_s[k];
                    tag_r[k]   <= src_tag_s[k];
                end
            end
            if (src_v_s[NBLK-1]) begin
                ovf_r <= ovf_s;
            end
        end
    end

    assign out_valid = valid_r[NBLK-1];
    assign sum       = acc_r[NBLK-1];
    assign cout      = carry_r[NBLK-1];
    assign ovf       = ovf_r;
    assign tag_out   = tag_r[NBLK-1];

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe: directed vectors, backpressure stream, random traffic and reset flush
// on a 16/4 instance, plus a single-block 8/8 instance.
module tb_csel_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    logic [3:0]  tag_in, tag_out;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic [3:0]  tag_in8, tag_out8;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    exp_t        q[$];
    logic        hold_prev = 1'b0;
    logic [22:0] held;
    logic [3:0]  tag_ctr = 4'd0;

    always #5 clk = ~clk;

    csel_adder_pipe #(.WIDTH(16), .BLOCK(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .tag_out(tag_out)
    );

    csel_adder_pipe #(.WIDTH(8), .BLOCK(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .tag_in(tag_in8),
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8),
        .ovf(ovf8), .tag_out(tag_out8)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands actually added.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic cv, input logic sv, input logic [3:0] tv);
        exp_t        e;
        logic [15:0] bb;
        logic        c;
        logic [16:0] full;
        int          s;
        bb     = sv ? ~bv : bv;
        c      = sv ? 1'b1 : cv;
        full   = {1'b0, av} + {1'b0, bb} + {16'd0, c};
        s      = int'($signed(av)) + int'($signed(bb)) + int'(c);
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (s > 32767) || (s < -32768);
        e.tag  = tv;
        return e;
    endfunction

    // One clock: sample at negedge+1, score handshakes, advance to the next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (hold_prev) check("hold", {out_valid, tag_out, cout, ovf, sum}, {9'd0, held});
        if (out_valid && !out_ready) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        if (rst) check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, tag_in));
        if (!rst && out_valid && out_ready) begin
            check("spurious", {31'd0, (q.size() > 0)}, 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sum", {16'd0, sum}, {16'd0, e.sum});
                check("cout", {31'd0, cout}, {31'd0, e.cout});
                check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                check("tag", {28'd0, tag_out}, {28'd0, e.tag});
            end
        end
        hold_prev = out_valid && !out_ready && !rst;
        held      = {out_valid, tag_out, cout, ovf, sum};
        @(posedge clk);
        if (rst) q.delete();
        @(negedge clk);
    endtask

    task automatic directed(input string name, input logic [15:0] av, input logic [15:0] bv,
                            input logic cv, input logic sv,
                            input logic [15:0] esum, input logic ecout, input logic eovf);
        int lat;
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        cin       = cv;
        sub       = sv;
        tag_in    = tag_ctr;
        tag_ctr   = tag_ctr + 4'd1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({name, "_lat"}, lat, 32'd3);
        check({name, "_sum"}, {16'd0, sum}, {16'd0, esum});
        check({name, "_cout"}, {31'd0, cout}, {31'd0, ecout});
        check({name, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
        tick();
    endtask

    initial begin
        int sent;
        int stream_rx;
        logic acc;

        rst = 1'b1; in_valid = 1'b0; a = 16'd0; b = 16'd0; cin = 1'b0; sub = 1'b0;
        tag_in = 4'd0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0; sub8 = 1'b0; tag_in8 = 4'd0;
        out_ready8 = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_tag", {28'd0, tag_out}, 32'd0);
        check("rst_out_valid8", {31'd0, out_valid8}, 32'd0);

        directed("basic",   16'h1234, 16'h0FF0, 1'b0, 1'b0, 16'h2224, 1'b0, 1'b0);
        directed("chain",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("posovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Eight back-to-back transactions with out_ready dropped on cycles 5-7.
        sent = 0;
        stream_rx = 0;
        for (int c = 0; c < 40 && stream_rx < 8; c++) begin
            in_valid  = (sent < 8);
            a         = 16'(sent);
            b         = 16'h0100;
            cin       = 1'b0;
            sub       = 1'b0;
            tag_in    = 4'(sent);
            out_ready = !(c >= 5 && c <= 7);
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check("stream_tag", {28'd0, tag_out}, stream_rx);
                check("stream_sum", {16'd0, sum}, 32'h0100 + stream_rx);
                stream_rx++;
            end
            tick();
            if (acc) sent++;
        end
        check("stream_count", stream_rx, 32'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            tag_in    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("drain", q.size(), 32'd0);

        // Three transactions in flight, then a one-edge reset.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            tag_in   = 4'(i + 8);
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        directed("post_rst", 16'h00A5, 16'h0011, 1'b0, 1'b0, 16'h00B6, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("flush_drain", q.size(), 32'd0);

        // Single-block instance: one cycle latency, back-to-back.
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; tag_in8 = 4'h3;
        #1;
        check("w8_in_ready", {31'd0, in_ready8}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; tag_in8 = 4'h5;
        #1;
        check("w8_valid", {31'd0, out_valid8}, 32'd1);
        check("w8_sum", {24'd0, sum8}, 32'h00);
        check("w8_cout", {31'd0, cout8}, 32'd1);
        check("w8_ovf", {31'd0, ovf8}, 32'd0);
        check("w8_tag", {28'd0, tag_out8}, 32'h3);
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        #1;
        check("w8_valid2", {31'd0, out_valid8}, 32'd1);
        check("w8_sum2", {24'd0, sum8}, 32'h31);
        check("w8_tag2", {28'd0, tag_out8}, 32'h5);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("w8_idle", {31'd0, out_valid8}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor with valid/ready streaming handshake.
- Operands split into NBLK = WIDTH/BLOCK blocks. Pipeline stage k resolves block k.
- Each stage precomputes both conditional block sums (carry-in 0 and 1) and selects one with the carry registered by stage k-1.
- Used as the datapath arithmetic unit wherever a wide add/sub at one result per cycle is needed at high clock rate.

Parameters:
- WIDTH, 16, operand/result width in bits.
- BLOCK, 4, bits per carry-select block. WIDTH % BLOCK != 0 is an elaboration error.
- TAG_W, 4, width of the sideband tag carried alongside each transaction.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  transaction offered.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Ignored when sub=1.
- sub  input  1  0: A+B+cin. 1: A-B, computed as A+~B+1.
- tag_in  input  TAG_W  sideband ID, passed through unmodified.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB. For sub this is the not-borrow flag.
- ovf  output  1  two's-complement signed overflow.
- tag_out  output  TAG_W  tag of the presented result.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous, active-high.
- Reset values: all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0, tag_out=0.
- in_ready is forced 0 while rst=1.
- Advance enable: adv = ~out_valid | out_ready. The whole pipeline shifts on adv=1 and holds all registers on adv=0 (global stall).
- in_ready = adv & ~rst.
- Accept condition: in_valid & in_ready at a rising edge.
  - Stage 0 captures block 0 result and block-0 carry, plus the remaining operand bits (B already inverted if sub), sub and tag.
  - If no transaction is accepted, stage 0 loads a bubble (valid=0).
- Stage k (1..NBLK-1): on adv, takes stage k-1 contents.
  - Computes s0/c0 and s1/c1 for block k.
  - Selects s1/c1 when the incoming registered carry is 1, else s0/c0.
  - Appends the selected block sum to the accumulated lower bits.
- Stage NBLK-1 is the output register, driving sum/cout/ovf/tag_out/out_valid directly.
- Latency: accepted at edge n → out_valid=1 after edge n+NBLK-1 (NBLK cycles) with no stall. NBLK=1 gives 1 cycle.
- Throughput: one transaction per cycle while out_ready=1.
- Stalls:
  - Held result (out_valid=1, out_ready=0) keeps sum/cout/ovf/tag_out stable until the handshake completes.
  - No transaction is dropped, duplicated or reordered.
- Bubbles propagate as valid=0. Their data contents are don't-care, but out data stays at its last value while out_valid=0.
- Carry-in to block 0 = sub ? 1 : cin.
- ovf = carry into MSB XOR carry out of MSB. This is equivalent to a[W-1]==b'[W-1] && sum[W-1]!=a[W-1], where b' is the B operand actually added.
- Wrap-around: results are modulo 2^WIDTH. No saturation.
- Simultaneous accept and output handshake in one cycle is legal and must sustain full throughput.
- Reset mid-operation: every in-flight transaction is discarded. out_valid=0 the cycle after the reset edge, and no pre-reset result ever appears.
- in_valid must not depend on in_ready. Inputs are sampled only on accept.

Test Plan:
- WIDTH=16, BLOCK=4: a=0x1234, b=0x0FF0, cin=0, sub=0, accepted edge 0 → out_valid after edge 3, sum=0x2224, cout=0, ovf=0.
- Full-chain carry: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0. Separately, a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- Subtract with cin=1 applied (must be ignored):
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Streaming with backpressure: 8 back-to-back transactions (tags 0..7, a=i, b=0x0100), out_ready low on cycles 5-7.
  - Required: in_ready=0 during the stall, held output stable.
  - All 8 results emerge in tag order with sum=0x0100+i; none lost or duplicated.
- Reset mid-flight: 3 transactions in the pipe, rst high for one edge.
  - Required: out_valid=0 the next cycle and none of the 3 ever emerge.
  - A new transaction accepted at edge r+1 appears after edge r+4.
- WIDTH=8, BLOCK=8 (NBLK=1): a=0xFF, b=0x01, cin=0 → after 1 cycle sum=0x00, cout=1, ovf=0, full throughput with out_ready=1.
